// File: rtl/neander_ctrl_if.sv
// Purpose: memory and ALU bus between the Neander control unit and its memory/ALU.
// Latency: wires only; no storage in the interface.
// Backpressure: none; memory answers one cycle after mem_addr, ALU is combinational.
//
// Signals: mem_addr/mem_wdata/mem_we (ctrl -> memory), mem_rdata (memory -> ctrl),
//          alu_a/alu_b/alu_sub/alu_sel (ctrl -> ALU), alu_fi (ALU -> ctrl).
interface neander_ctrl_if;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic       alu_sub;
  logic [1:0] alu_sel;
  logic [7:0] alu_fi;

  modport master (
    output mem_addr, mem_wdata, mem_we, alu_a, alu_b, alu_sub, alu_sel,
    input  mem_rdata, alu_fi
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_we, alu_a, alu_b, alu_sub, alu_sel,
    output mem_rdata, alu_fi
  );
endinterface

// File: rtl/neander_ctrl.sv
// Purpose: Neander control unit and register file (PC, REM, RI, AC, N/Z), master of memory and ALU.
// Latency: 2 (NOP/HLT), 3 (NOT), 4 (jumps), 5 (STA), 6 (LDA/ADD/SUB/AND/OR) cycles per instruction.
// Backpressure: none; memory read data is assumed valid exactly one cycle after mem_addr.
//
// Ports: clk, rst_n (async active-low); bus (neander_ctrl_if.master) memory + ALU;
//        pc, ac, flag_n, flag_z, halted are debug/status outputs.
module neander_ctrl #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  neander_ctrl_if.master        bus,
  output logic [7:0]            pc,
  output logic [7:0]            ac,
  output logic                  flag_n,
  output logic                  flag_z,
  output logic                  halted
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_NOTX, S_OPADDR, S_OPLATCH, S_MEMRD, S_EXEC, S_MEMWR, S_HALT
  } state_t;

  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_SUB = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JN  = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t     state, state_nxt;
  logic [7:0] rem;
  logic [3:0] ri;
  logic       pc_inc;
  logic       pc_load;
  logic       ac_we;
  logic [7:0] ac_din;

  assign bus.mem_wdata = ac;
  assign bus.alu_a     = ac;
  assign bus.alu_b     = bus.mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    bus.mem_addr = pc;
    bus.mem_we   = 1'b0;
    bus.alu_sel  = 2'b00;
    bus.alu_sub  = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    ac_we        = 1'b0;
    ac_din       = ac;
    halted       = 1'b0;
    case (state)
      S_FETCH: begin
        pc_inc    = 1'b1;
        state_nxt = S_DECODE;
      end
      // Decode straight from the read data; RI is loaded on the same edge.
      S_DECODE: begin
        case (bus.mem_rdata[7:4])
          OP_NOT: state_nxt = S_NOTX;
          OP_HLT: state_nxt = S_HALT;
          OP_STA, OP_LDA, OP_ADD, OP_OR, OP_AND, OP_SUB, OP_JMP, OP_JN, OP_JZ:
            state_nxt = S_OPADDR;
          default: state_nxt = S_FETCH;
        endcase
      end
      S_NOTX: begin
        ac_we     = 1'b1;
        ac_din    = ~ac;
        state_nxt = S_FETCH;
      end
      S_OPADDR: begin
        pc_inc    = 1'b1;
        state_nxt = S_OPLATCH;
      end
      // Untaken jumps leave PC alone: it already points past the operand.
      S_OPLATCH: begin
        case (ri)
          OP_JMP:  pc_load = 1'b1;
          OP_JN:   pc_load = flag_n;
          OP_JZ:   pc_load = flag_z;
          default: pc_load = 1'b0;
        endcase
        if (ri == OP_JMP || ri == OP_JN || ri == OP_JZ) state_nxt = S_FETCH;
        else if (ri == OP_STA)                          state_nxt = S_MEMWR;
        else                                            state_nxt = S_MEMRD;
      end
      S_MEMRD: begin
        bus.mem_addr = rem;
        state_nxt    = S_EXEC;
      end
      S_EXEC: begin
        case (ri)
          OP_LDA:  bus.alu_sel = 2'b01;
          OP_AND:  bus.alu_sel = 2'b10;
          OP_OR:   bus.alu_sel = 2'b11;
          OP_SUB:  bus.alu_sub = 1'b1;
          default: bus.alu_sel = 2'b00;
        endcase
        ac_we     = 1'b1;
        ac_din    = bus.alu_fi;
        state_nxt = S_FETCH;
      end
      S_MEMWR: begin
        bus.mem_addr = rem;
        bus.mem_we   = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      ac     <= 8'h00;
      rem    <= 8'h00;
      ri     <= 4'h0;
      flag_n <= 1'b0;
      flag_z <= 1'b1;
    end else begin
      if (pc_load)     pc <= bus.mem_rdata;
      else if (pc_inc) pc <= pc + 8'd1;
      if (state == S_DECODE)  ri  <= bus.mem_rdata[7:4];
      if (state == S_OPLATCH) rem <= bus.mem_rdata;
      // Flags track AC and only move when AC is written.
      if (ac_we) begin
        ac     <= ac_din;
        flag_n <= ac_din[7];
        flag_z <= (ac_din == 8'h00);
      end
    end
  end

endmodule

// File: doc/neander_ctrl.md
# neander_ctrl

Control unit and register file for the Neander processor. It fetches and decodes instructions from a synchronous byte memory and holds PC, REM, RI, AC and the N/Z flags. It drives the operand, subtract and select inputs of the existing 8-bit ALU, then writes the ALU result back into AC. The ALU is purely combinational; this block is the sequential master that uses it.

## Interface

Parameters:
- `RESET_PC`, 8'h00, PC value loaded on reset.

Ports:
- `clk`, input, 1, single clock; all state updates on the rising edge.
- `rst_n`, input, 1, asynchronous active-low reset.
- `mem_addr`, output, 8, memory address. Combinational from state.
- `mem_rdata`, input, 8, read data. Valid the cycle after `mem_addr` is presented.
- `mem_wdata`, output, 8, always equal to AC.
- `mem_we`, output, 1, write strobe, sampled by memory at the clock edge.
- `alu_a`, output, 8, always equal to AC.
- `alu_b`, output, 8, always equal to `mem_rdata`.
- `alu_sub`, output, 1, 1 selects A−B (two's complement); 0 selects A+B.
- `alu_sel`, output, 2, 00 = sum/difference, 01 = pass B, 10 = A AND B, 11 = A OR B.
- `alu_fi`, input, 8, ALU result.
- `pc`, output, 8, current PC (debug).
- `ac`, output, 8, current AC (debug).
- `flag_n`, output, 1, negative flag.
- `flag_z`, output, 1, zero flag.
- `halted`, output, 1, high while in HALT.

## Operation

Opcode is `mem_rdata[7:4]` of the instruction byte; the low nibble is ignored.
- 0 NOP: 1 byte.
- 1 STA addr: 2 bytes.
- 2 LDA addr: 2 bytes.
- 3 ADD addr: 2 bytes.
- 4 OR addr: 2 bytes.
- 5 AND addr: 2 bytes.
- 6 NOT: 1 byte.
- 7 SUB addr: 2 bytes.
- 8 JMP addr: 2 bytes.
- 9 JN addr: 2 bytes.
- A JZ addr: 2 bytes.
- F HLT: 1 byte.
- Opcodes B–E execute as NOP.

States and transitions:
- FETCH: `mem_addr`=PC; PC<=PC+1; → DECODE.
- DECODE: RI<=opcode.
  - NOP/unknown → FETCH.
  - NOT → NOTX.
  - HLT → HALT.
  - All others → OPADDR.
- NOTX: AC<=~AC; update flags; → FETCH. The ALU is not used.
- OPADDR: `mem_addr`=PC; PC<=PC+1; → OPLATCH.
- OPLATCH: REM<=`mem_rdata`.
  - JMP: PC<=`mem_rdata`.
  - JN: PC<=`mem_rdata` if N=1.
  - JZ: PC<=`mem_rdata` if Z=1.
  - Jumps → FETCH. STA → MEMWR. Others → MEMRD.
  - A jump that is not taken keeps PC, which already points past the operand.
- MEMRD: `mem_addr`=REM; → EXEC.
- EXEC: AC<=`alu_fi`; update flags; → FETCH.
  - LDA: `alu_sel`=01.
  - ADD: `alu_sel`=00, `alu_sub`=0.
  - SUB: `alu_sel`=00, `alu_sub`=1.
  - AND: `alu_sel`=10.
  - OR: `alu_sel`=11.
- MEMWR: `mem_addr`=REM; `mem_we`=1; → FETCH.
- HALT: no state changes. `halted`=1. Only reset exits this state.

Rules:
- In every state not listed above, `mem_addr`=PC, `mem_we`=0, `alu_sel`=00, `alu_sub`=0.
- Arithmetic is modulo 256. Carry and overflow are discarded and no carry flag exists.
- Flags update only when AC is written: N=AC[7], Z=(AC==0).
- PC increments wrap from 0xFF to 0x00. A 2-byte instruction at 0xFF takes its operand from 0x00.

## Timing

- Reset (asynchronous, any state, including mid-instruction):
  - State=FETCH, PC=`RESET_PC`, AC=0, REM=0, RI=0.
  - N=0, Z=1.
  - `mem_we`=0, `halted`=0.
  - A write whose MEMWR edge has not yet occurred is abandoned.
- Cycles per instruction:
  - NOP/unknown: 2.
  - NOT: 3.
  - JMP/JN/JZ: 4, taken or not.
  - STA: 5.
  - LDA/ADD/SUB/AND/OR: 6.
  - HLT: 2, then HALT.
- Exactly one `mem_we` pulse per STA, lasting one cycle.
- STA to X followed immediately by LDA X returns the stored value, because the memory write completes before the next read.
- AC, `flag_n` and `flag_z` change only on the final edge of an instruction.

## Test plan

- Reset release with memory all 0x00: PC increments by 1 every 2 cycles, AC=0, Z=1, `mem_we` never asserted. Assert `rst_n` low during DECODE: PC returns to 0 immediately, without waiting for a clock edge.
- Program LDA 0x80; ADD 0x81; STA 0x82; HLT with [0x80]=0x7F and [0x81]=0x01:
  - [0x82]=0x80, AC=0x80, N=1, Z=0.
  - `halted` rises at cycle 19.
  - PC stays at 0x07 while halted.
- SUB of a value from itself (AC=0x35, [addr]=0x35): AC=0x00, Z=1, N=0, with `alu_sub`=1 during EXEC only. ADD 0xFF+0x02 gives AC=0x01 (carry dropped).
- JZ with Z=0 falls through to PC+2. JZ with Z=1 loads the operand. JN behaves the same with N. Each jump takes 4 cycles.
- NOT with AC=0xFF gives AC=0x00 and Z=1. AND 0xF0&0x3C gives 0x30. OR 0xF0|0x0F gives 0xFF with N=1.
- Wrap-around: `RESET_PC`=0xFF, [0xFF]=0x80 (JMP), [0x00]=0x10 → PC=0x10 after 4 cycles.
